// File: rtl/aes_inv_key_sched_pkg.sv
// Shared constants and types for the reverse AES-128 key schedule.
package aes_inv_key_sched_pkg;

   localparam int unsigned KEY_W      = 128;
   localparam int unsigned WORD_W     = 32;
   localparam int unsigned ROUND_W    = 4;
   localparam int unsigned BYTE_W     = 8;
   localparam int unsigned BYTE_IDX_W = 2;

   localparam logic [ROUND_W-1:0]    ROUND_LAST = ROUND_W'(10);
   localparam logic [BYTE_IDX_W-1:0] BYTE_LAST  = BYTE_IDX_W'(3);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      UPD  = 2'd2
   } stateT;

   // Round key as four words, w0 in the most significant position.
   typedef struct packed {
      logic [WORD_W-1:0] w0;
      logic [WORD_W-1:0] w1;
      logic [WORD_W-1:0] w2;
      logic [WORD_W-1:0] w3;
   } keyT;

   localparam logic [BYTE_W-1:0] RCON [1:10] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   // Round constant for a round index; zero outside 1..10.
   function automatic logic [BYTE_W-1:0] rconOf(input logic [ROUND_W-1:0] round);
      if (round >= ROUND_W'(1) && round <= ROUND_LAST) begin
         return RCON[round];
      end
      return '0;
   endfunction

endpackage

// File: rtl/unshared_sbox.sv
// Combinational forward AES S-box, one byte in, one byte out.
module unshared_sbox
   import aes_inv_key_sched_pkg::*;
(
   input  logic [BYTE_W-1:0] InxDI,
   output logic [BYTE_W-1:0] OutxDO
);

   localparam logic [BYTE_W-1:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   assign OutxDO = SBOX[InxDI];

endmodule

// File: rtl/aes_inv_key_sched.sv
// Reverse AES-128 key schedule: emits round keys 10 down to 0, one every five
// cycles, using a single S-box time-multiplexed over the SubWord bytes.
module aes_inv_key_sched
   import aes_inv_key_sched_pkg::*;
(
   input  logic               ClkxCI,
   input  logic               RstxBI,
   input  logic               StartxSI,
   input  logic [KEY_W-1:0]   KeyxDI,
   output logic [KEY_W-1:0]   RkxDO,
   output logic [ROUND_W-1:0] RoundxDO,
   output logic               RkValidxSO,
   output logic               BusyxSO,
   output logic               DonexSO
);

   stateT                  stateP, stateN;
   keyT                    keyP, keyN;
   logic [ROUND_W-1:0]     roundP, roundN;
   logic [BYTE_IDX_W-1:0]  byteP, byteN;
   logic [WORD_W-1:0]      tempP, tempN;
   logic                   rkValidP, rkValidN;
   logic                   doneP, doneN;
   logic                   busyP, busyN;

   logic [WORD_W-1:0]      tWord;
   logic [WORD_W-1:0]      rotWord;
   logic [BYTE_W-1:0]      sboxIn;
   logic [BYTE_W-1:0]      sboxOut;
   logic [3:0]             byteWe;

   // Last word of the previous round key, recovered from the current one.
   assign tWord   = keyP.w3 ^ keyP.w2;
   assign rotWord = {tWord[23:0], tWord[31:24]};

   // Byte mux on Rot; byte 0 is the most significant byte.
   always_comb begin
      case (byteP)
         2'd0:    sboxIn = rotWord[31:24];
         2'd1:    sboxIn = rotWord[23:16];
         2'd2:    sboxIn = rotWord[15:8];
         default: sboxIn = rotWord[7:0];
      endcase
   end

   unshared_sbox uSbox (
      .InxDI  (sboxIn),
      .OutxDO (sboxOut)
   );

   always_comb begin
      byteWe = '0;
      if (stateP == SUB) begin
         byteWe = 4'b0001 << byteP;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      stateN   = stateP;
      keyN     = keyP;
      roundN   = roundP;
      byteN    = byteP;
      tempN    = tempP;
      rkValidN = 1'b0;
      doneN    = 1'b0;

      case (stateP)
         IDLE: begin
            if (StartxSI) begin
               keyN     = keyT'(KeyxDI);
               roundN   = ROUND_LAST;
               byteN    = '0;
               rkValidN = 1'b1;
               stateN   = SUB;
            end
         end
         SUB: begin
            if (byteWe[0]) tempN[31:24] = sboxOut;
            if (byteWe[1]) tempN[23:16] = sboxOut;
            if (byteWe[2]) tempN[15:8]  = sboxOut;
            if (byteWe[3]) tempN[7:0]   = sboxOut;
            byteN = byteP + BYTE_IDX_W'(1);
            if (byteP == BYTE_LAST) begin
               stateN = UPD;
            end
         end
         UPD: begin
            keyN.w0  = keyP.w0 ^ tempP ^ {rconOf(roundP), 24'h0};
            keyN.w1  = keyP.w1 ^ keyP.w0;
            keyN.w2  = keyP.w2 ^ keyP.w1;
            keyN.w3  = keyP.w3 ^ keyP.w2;
            roundN   = roundP - ROUND_W'(1);
            rkValidN = 1'b1;
            if (roundP == ROUND_W'(1)) begin
               doneN  = 1'b1;
               stateN = IDLE;
            end else begin
               byteN  = '0;
               stateN = SUB;
            end
         end
         default: begin
            stateN = IDLE;
         end
      endcase

      busyN = (stateN != IDLE);
   end

   always_ff @(posedge ClkxCI or negedge RstxBI) begin
      if (!RstxBI) begin
         stateP   <= IDLE;
         keyP     <= '0;
         roundP   <= '0;
         byteP    <= '0;
         tempP    <= '0;
         rkValidP <= 1'b0;
         doneP    <= 1'b0;
         busyP    <= 1'b0;
      end else begin
         stateP   <= stateN;
         keyP     <= keyN;
         roundP   <= roundN;
         byteP    <= byteN;
         tempP    <= tempN;
         rkValidP <= rkValidN;
         doneP    <= doneN;
         busyP    <= busyN;
      end
   end

   assign RkxDO      = keyP;
   assign RoundxDO   = roundP;
   assign RkValidxSO = rkValidP;
   assign BusyxSO    = busyP;
   assign DonexSO    = doneP;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Bench for aes_inv_key_sched: word-level AES key expansion model with a
// per-cycle comparison of every output, plus FIPS-197 literal pins.
module tb_aes_inv_key_sched;

   logic         ClkxCI     = 1'b0;
   logic         RstxBI     = 1'b0;
   logic         StartxSI   = 1'b0;
   logic [127:0] KeyxDI     = '0;
   logic [127:0] RkxDO;
   logic [3:0]   RoundxDO;
   logic         RkValidxSO;
   logic         BusyxSO;
   logic         DonexSO;

   aes_inv_key_sched dut (
      .ClkxCI     (ClkxCI),
      .RstxBI     (RstxBI),
      .StartxSI   (StartxSI),
      .KeyxDI     (KeyxDI),
      .RkxDO      (RkxDO),
      .RoundxDO   (RoundxDO),
      .RkValidxSO (RkValidxSO),
      .BusyxSO    (BusyxSO),
      .DonexSO    (DonexSO)
   );

   always #5 ClkxCI = ~ClkxCI;

   localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_K9  = 128'hac7766f319fadc2128d12941575c006e;
   localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

   int nChecks = 0;
   int nPass   = 0;
   int curCyc  = 0;

   logic [7:0] sbox [256];
   logic [7:0] rcon [1:10];

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      nChecks++;
      if (got === exp) nPass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
   endtask

   // GF(2^8) helpers for building the S-box from its algebraic definition.
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      logic [7:0] y;
      p = 8'h00; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = xtime(x);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl1(input logic [7:0] x);
      return {x[6:0], x[7]};
   endfunction

   function automatic logic [31:0] subWord(input logic [31:0] w);
      return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
   endfunction

   function automatic logic [31:0] rotWord(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   // Undo the FIPS-197 expansion word by word, from w[43..40] down to w[3..0].
   function automatic logic [127:0] invK0(input logic [127:0] k10);
      logic [31:0] w [64];
      logic [31:0] t;
      w[40] = k10[127:96]; w[41] = k10[95:64]; w[42] = k10[63:32]; w[43] = k10[31:0];
      for (int i = 43; i >= 4; i--) begin
         t = w[6'(i - 1)];
         if (i % 4 == 0) t = subWord(rotWord(t)) ^ {rcon[4'(i / 4)], 24'h0};
         w[6'(i - 4)] = w[6'(i)] ^ t;
      end
      return {w[0], w[1], w[2], w[3]};
   endfunction

   // Forward FIPS-197 expansion from the cipher key, returning round key r.
   function automatic logic [127:0] fwdKey(input logic [127:0] k0, input int r);
      logic [31:0] w [64];
      logic [31:0] t;
      w[0] = k0[127:96]; w[1] = k0[95:64]; w[2] = k0[63:32]; w[3] = k0[31:0];
      for (int i = 4; i < 4 * r + 4; i++) begin
         t = w[6'(i - 1)];
         if (i % 4 == 0) t = subWord(rotWord(t)) ^ {rcon[4'(i / 4)], 24'h0};
         w[6'(i)] = w[6'(i - 4)] ^ t;
      end
      return {w[6'(4 * r)], w[6'(4 * r + 1)], w[6'(4 * r + 2)], w[6'(4 * r + 3)]};
   endfunction

   // Reference model: cycle index since start, c=1..51; c=0 means idle.
   logic [127:0] mKeys [0:10];
   int           mCyc      = 0;
   logic [127:0] holdRk    = '0;
   logic [3:0]   holdRound = '0;
   int           validCnt  = 0;
   int           doneCnt   = 0;

   always @(negedge ClkxCI) begin
      logic [127:0] eRk;
      logic [3:0]   eRound;
      logic         eValid;
      logic         eBusy;
      logic         eDone;
      logic [127:0] k0;
      int           r;
      if (!RstxBI) begin
         mCyc = 0; holdRk = '0; holdRound = '0;
      end
      if (mCyc == 0) begin
         eRk = holdRk; eRound = holdRound; eValid = 1'b0; eBusy = 1'b0; eDone = 1'b0;
      end else begin
         r      = 10 - (mCyc - 1) / 5;
         eRk    = mKeys[4'(r)];
         eRound = 4'(r);
         eValid = ((mCyc - 1) % 5 == 0);
         eBusy  = (mCyc <= 50);
         eDone  = (mCyc == 51);
      end
      check("cyc_rk",    RkxDO,               eRk);
      check("cyc_round", 128'(RoundxDO),      128'(eRound));
      check("cyc_valid", 128'(RkValidxSO),    128'(eValid));
      check("cyc_busy",  128'(BusyxSO),       128'(eBusy));
      check("cyc_done",  128'(DonexSO),       128'(eDone));
      if (RkValidxSO) validCnt++;
      if (DonexSO) doneCnt++;
      if (RstxBI) begin
         if (mCyc == 0 || mCyc == 51) begin
            if (mCyc == 51) begin
               holdRk = mKeys[0]; holdRound = 4'd0;
            end
            if (StartxSI) begin
               k0 = invK0(KeyxDI);
               for (int i = 0; i <= 10; i++) mKeys[4'(i)] = fwdKey(k0, i);
               mCyc = 1;
            end else begin
               mCyc = 0;
            end
         end else begin
            mCyc++;
         end
      end
   end

   // Driver helpers: inputs only change 2 time units after a rising edge.
   task automatic tick();
      @(posedge ClkxCI);
      #2;
   endtask

   task automatic toCycle(input int n);
      while (curCyc < n) begin
         tick();
         curCyc++;
      end
   endtask

   task automatic startRun(input logic [127:0] k, input bit hold);
      StartxSI = 1'b1;
      KeyxDI   = k;
      tick();
      curCyc = 1;
      if (!hold) StartxSI = 1'b0;
   endtask

   function automatic logic [127:0] randKey();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      logic [7:0]   b;
      logic [7:0]   inv;
      logic [127:0] keyA;
      logic [127:0] keyB;
      int           v0;
      int           d0;

      for (int i = 0; i < 256; i++) begin
         inv = 8'h00;
         for (int j = 1; j < 256; j++)
            if (gmul(8'(i), 8'(j)) == 8'h01) inv = 8'(j);
         b = inv;
         sbox[8'(i)] = b ^ rotl1(b) ^ rotl1(rotl1(b)) ^ rotl1(rotl1(rotl1(b)))
                       ^ rotl1(rotl1(rotl1(rotl1(b)))) ^ 8'h63;
      end
      rcon[1] = 8'h01;
      for (int i = 2; i <= 10; i++) rcon[4'(i)] = xtime(rcon[4'(i - 1)]);

      check("pin_sbox00", 128'(sbox[8'h00]), 128'h63);
      check("pin_sbox53", 128'(sbox[8'h53]), 128'hed);
      check("pin_rcon9",  128'(rcon[9]),     128'h1b);
      check("pin_rcon10", 128'(rcon[10]),    128'h36);
      check("pin_inv_k0", invK0(FIPS_K10),   FIPS_K0);
      check("pin_fwd_k9", fwdKey(FIPS_K0, 9), FIPS_K9);
      check("pin_fwd_k10", fwdKey(FIPS_K0, 10), FIPS_K10);

      tick(); tick(); tick();
      RstxBI = 1'b1;
      tick();

      // FIPS-197 Appendix A run.
      v0 = validCnt; d0 = doneCnt;
      startRun(FIPS_K10, 1'b0);
      @(negedge ClkxCI);
      check("fips_c1_rk",    RkxDO,             FIPS_K10);
      check("fips_c1_round", 128'(RoundxDO),    128'd10);
      check("fips_c1_valid", 128'(RkValidxSO),  128'd1);
      toCycle(6);
      @(negedge ClkxCI);
      check("fips_c6_rk",    RkxDO,             FIPS_K9);
      check("fips_c6_round", 128'(RoundxDO),    128'd9);
      toCycle(51);
      @(negedge ClkxCI);
      check("fips_c51_rk",    RkxDO,            FIPS_K0);
      check("fips_c51_done",  128'(DonexSO),    128'd1);
      check("fips_c51_round", 128'(RoundxDO),   128'd0);
      check("fips_c51_busy",  128'(BusyxSO),    128'd0);

      // Idle hold for 20 cycles after Done.
      toCycle(71);
      @(negedge ClkxCI);
      check("idle_rk",      RkxDO,                 FIPS_K0);
      check("idle_busy",    128'(BusyxSO),         128'd0);
      check("fips_nvalid",  128'(validCnt - v0),   128'd11);
      check("fips_ndone",   128'(doneCnt - d0),    128'd1);
      tick();

      // Start held high across a whole run with a changed key.
      keyA = randKey();
      keyB = randKey();
      startRun(keyA, 1'b1);
      KeyxDI = keyB;
      @(negedge ClkxCI);
      check("hold_c1_rk", RkxDO, keyA);
      toCycle(51);
      @(negedge ClkxCI);
      check("hold_c51_rk",   RkxDO,          invK0(keyA));
      check("hold_c51_done", 128'(DonexSO),  128'd1);
      tick();
      curCyc = 1;
      StartxSI = 1'b0;
      @(negedge ClkxCI);
      check("hold_c52_rk",    RkxDO,            keyB);
      check("hold_c52_round", 128'(RoundxDO),   128'd10);
      toCycle(51);
      @(negedge ClkxCI);
      check("hold_b_k0", RkxDO, invK0(keyB));
      tick();

      // Asynchronous reset in cycle 23, between clock edges.
      startRun(randKey(), 1'b0);
      toCycle(23);
      #1 RstxBI = 1'b0;
      #1;
      check("rst_rk",    RkxDO,              128'd0);
      check("rst_round", 128'(RoundxDO),     128'd0);
      check("rst_valid", 128'(RkValidxSO),   128'd0);
      check("rst_busy",  128'(BusyxSO),      128'd0);
      check("rst_done",  128'(DonexSO),      128'd0);
      tick(); tick();
      RstxBI = 1'b1;
      tick();
      keyA = randKey();
      startRun(keyA, 1'b0);
      toCycle(51);
      @(negedge ClkxCI);
      check("post_rst_k0", RkxDO, invK0(keyA));
      tick();

      // Random keys, with some back-to-back restarts.
      for (int n = 0; n < 200; n++) begin
         startRun(randKey(), 1'b0);
         toCycle(51);
         repeat ($urandom_range(0, 3)) tick();
      end
      repeat (6) tick();

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
